// File: rtl/axis_pkg.sv
// axis_pkg: shared sample types plus complex divider widths and FSM state encoding
package axis_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SAMPLE_NUM_W = 2*SAMPLE_W+1;
  typedef struct packed {
    logic signed [SAMPLE_NUM_W-1:0] re;
    logic signed [SAMPLE_NUM_W-1:0] im;
  } sample_t;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } sample_t_int;
  localparam int CDIV_P_W = SAMPLE_NUM_W + SAMPLE_W;
  localparam int CDIV_MAG_W = 2*SAMPLE_W+1;
  typedef enum logic [2:0] {IDLE, PREP, DIV, SAT, DONE} cdiv_state_t;
endpackage

// File: rtl/uint_serial_div.sv
// uint_serial_div: unsigned restoring divider, one quotient bit per step, MSB first; iteration count owned by the caller
module uint_serial_div #(
  parameter int N = 48,
  parameter int M = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic [N-1:0] quotient
);
  logic [M-1:0] rem;
  logic [M:0] trial, diff;
  assign trial = {rem, quotient[N-1]};
  assign diff = trial - {1'b0, divisor};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      quotient <= '0;
    end else if (start) begin
      rem <= '0;
      quotient <= dividend;
    end else if (step) begin
      rem <= diff[M] ? trial[M-1:0] : diff[M-1:0];
      quotient <= {quotient[N-2:0], ~diff[M]};
    end
endmodule

// File: rtl/complex_int_div.sv
// complex_int_div: iterative complex integer divider q = n / d with saturation and divide-by-zero flag
// COMPLEX_INT_DIV_ROUND_EN selects round half away from zero instead of truncation.
module complex_int_div
  import axis_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int NUM_W = 2*DATA_W+1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NUM_W-1:0]  n,
  input  logic [2*DATA_W-1:0] d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] q,
  output logic                dz
);
`ifdef COMPLEX_INT_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int P_W = NUM_W + DATA_W;
  localparam int PS_W = P_W + 1;
  localparam int MAG_W = 2*DATA_W+1;
  localparam int DV_W = P_W + RND;
  localparam int IT = DV_W - 1;
  localparam int CW = $clog2(IT);
  cdiv_state_t state, nxt;
  logic [2*NUM_W-1:0] n_r;
  logic [2*DATA_W-1:0] d_r;
  logic [MAG_W-1:0] mag_c, mag_r;
  logic [CW-1:0] cnt;
  logic neg_re, neg_im, ovf_re, ovf_im, dz_int;
  logic signed [NUM_W-1:0] n_re, n_im;
  logic signed [DATA_W-1:0] d_re, d_im;
  logic signed [PS_W-1:0] p_re, p_im;
  logic [P_W-1:0] abs_re, abs_im;
  logic [DV_W-1:0] dv_re, dv_im;
  logic [IT-1:0] qu_re, qu_im;
  assign n_re = n_r[2*NUM_W-1:NUM_W];
  assign n_im = n_r[NUM_W-1:0];
  assign d_re = d_r[2*DATA_W-1:DATA_W];
  assign d_im = d_r[DATA_W-1:0];
  assign p_re = PS_W'(n_re) * PS_W'(d_re) + PS_W'(n_im) * PS_W'(d_im);
  assign p_im = PS_W'(n_im) * PS_W'(d_re) - PS_W'(n_re) * PS_W'(d_im);
  assign mag_c = MAG_W'(d_re) * MAG_W'(d_re) + MAG_W'(d_im) * MAG_W'(d_im);
  assign abs_re = P_W'(p_re[PS_W-1] ? -p_re : p_re);
  assign abs_im = P_W'(p_im[PS_W-1] ? -p_im : p_im);
`ifdef COMPLEX_INT_DIV_ROUND_EN
  assign dv_re = {1'b0, abs_re} + DV_W'(mag_c >> 1);
  assign dv_im = {1'b0, abs_im} + DV_W'(mag_c >> 1);
`else
  assign dv_re = abs_re;
  assign dv_im = abs_im;
`endif
  // The dividend MSB is not iterated: when set the quotient exceeds any DATA_W range, so it only forces saturation
  uint_serial_div #(.N(IT), .M(MAG_W)) u_div_re (
    .clk(clk), .rst_n(rst_n), .start(state == PREP), .step(state == DIV),
    .dividend(dv_re[IT-1:0]), .divisor(mag_r), .quotient(qu_re)
  );
  uint_serial_div #(.N(IT), .M(MAG_W)) u_div_im (
    .clk(clk), .rst_n(rst_n), .start(state == PREP), .step(state == DIV),
    .dividend(dv_im[IT-1:0]), .divisor(mag_r), .quotient(qu_im)
  );
  function automatic logic [DATA_W-1:0] sat(input logic neg, input logic ovf, input logic [IT-1:0] qu);
    logic [IT-1:0] lim;
    lim = neg ? IT'(2**(DATA_W-1)) : IT'(2**(DATA_W-1)-1);
    return (ovf || qu > lim) ? {neg, {(DATA_W-1){~neg}}} : (neg ? -qu[DATA_W-1:0] : qu[DATA_W-1:0]);
  endfunction
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = in_valid ? PREP : IDLE;
      PREP: nxt = (mag_c == '0) ? SAT : DIV;
      DIV: nxt = (cnt == CW'(IT-1)) ? SAT : DIV;
      SAT: nxt = DONE;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      n_r <= '0;
      d_r <= '0;
      mag_r <= '0;
      cnt <= '0;
      {neg_re, neg_im, ovf_re, ovf_im, dz_int} <= '0;
      q <= '0;
      dz <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        n_r <= n;
        d_r <= d;
      end
      if (state == PREP) begin
        mag_r <= mag_c;
        neg_re <= p_re[PS_W-1];
        neg_im <= p_im[PS_W-1];
        ovf_re <= dv_re[DV_W-1];
        ovf_im <= dv_im[DV_W-1];
        dz_int <= mag_c == '0;
      end
      cnt <= (state == DIV) ? cnt + 1'b1 : '0;
      if (state == SAT) begin
        q <= dz_int ? '0 : {sat(neg_re, ovf_re, qu_re), sat(neg_im, ovf_im, qu_im)};
        dz <= dz_int;
      end
    end
endmodule

// File: tb/tb_complex_int_div.sv
// tb_complex_int_div: directed vectors for complex_int_div, honours COMPLEX_INT_DIV_ROUND_EN
module tb_complex_int_div;
  import axis_pkg::*;
  localparam int DW = 16;
  localparam int NW = 33;
`ifdef COMPLEX_INT_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT = CDIV_P_W + 1 + RND;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, dz;
  logic [2*NW-1:0] n = '0;
  logic [2*DW-1:0] d = '0;
  logic [2*DW-1:0] q;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  complex_int_div dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .n(n), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .dz(dz)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input longint nr, input longint ni, input longint dr, input longint di);
    @(negedge clk);
    n = {NW'(nr), NW'(ni)};
    d = {DW'(dr), DW'(di)};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic run_op(input string tag, input longint nr, input longint ni, input longint dr, input longint di,
                        input int er, input int ei, input logic edz, input int elat, input bit early, input bit stall);
    int lat;
    logic [2*DW-1:0] eq;
    lat = 0;
    eq = {DW'(er), DW'(ei)};
    out_ready = early;
    send(nr, ni, dr, di);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " q"}, 64'(q), 64'(eq));
    check({tag, " dz"}, 64'(dz), 64'(edz));
    if (stall)
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n = '1;
        d = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, " stall q"}, 64'(q), 64'(eq));
        check({tag, " stall dz"}, 64'(dz), 64'(edz));
        check({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
      end
    if (!early) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " in_ready after"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid after"}, 64'(out_valid), 64'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset q", 64'(q), 64'd0);
    check("reset dz", 64'(dz), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("basic", 6, 8, 3, 4, 2, 0, 1'b0, LAT, 1'b0, 1'b0);
    run_op("imag", 25, 0, 0, 5, 0, -5, 1'b0, LAT, 1'b0, 1'b0);
    run_op("neg half", -7, 0, 2, 0, RND ? -4 : -3, 0, 1'b0, LAT, 1'b0, 1'b0);
    run_op("pos half", 7, 0, 2, 0, RND ? 4 : 3, 0, 1'b0, LAT, 1'b1, 1'b0);
    run_op("saturate", 64'sd1048576, -64'sd1048576, 1, 0, 32767, -32768, 1'b0, LAT, 1'b0, 1'b1);
    run_op("div zero", 123, -45, 0, 0, 0, 0, 1'b1, 2, 1'b0, 1'b0);
    run_op("min divisor", 64'sd1073741824, 0, -32768, 0, -32768, 0, 1'b0, LAT, 1'b0, 1'b0);
    run_op("wide overflow", -64'sd4294967296, -64'sd4294967296, -32768, -32768, 32767, 0, 1'b0, LAT, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(6, 8, 3, 4);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort q", 64'(q), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("after abort", 6, 8, 3, 4, 2, 0, 1'b0, LAT, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
